// File: rtl/uart_pkg.sv
// Shared definitions for the 16-bit command link: baud constants, the byte-sequencing
// state enum and the 2-bit command field encodings used in veer/stop words.
package uart_pkg;

  localparam int BAUD_DIV_DEFAULT = 5208;
  localparam int FAST_SIM_BAUD    = 16;
  localparam int BAUD_CNT_W       = 13;
  localparam int BIT_CNT_W        = 4;

  localparam logic [BIT_CNT_W-1:0] STOP_BIT_IDX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    GAP     = 2'd2,
    SEND_LO = 2'd3
  } tx_state_e;

  localparam logic [1:0] CMD_STOP       = 2'b00;
  localparam logic [1:0] CMD_VEER_RIGHT = 2'b01;
  localparam logic [1:0] CMD_VEER_LEFT  = 2'b10;
  localparam logic [1:0] CMD_REVERSE    = 2'b11;

  // Field idx of a veer/stop command word; field 0 is the LSB pair, consumed first.
  function automatic logic [1:0] cmd_field(input logic [15:0] word, input int idx);
    return word[2*idx +: 2];
  endfunction

  function automatic int effective_baud(input int baud_div, input int fast_sim);
    return (fast_sim != 0) ? FAST_SIM_BAUD : baud_div;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// Single-byte UART transmitter: start bit, 8 data bits LSB first, stop bit.
// tx_done is high during the last clock of the stop bit so the sequencer can act on that edge.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_DIV - 1);

  logic                  busy_q, busy_d;
  logic [BAUD_CNT_W-1:0] baud_q, baud_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [8:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  baud_wrap;

  assign baud_wrap = busy_q && (baud_q == BAUD_LAST);
  assign tx_done   = baud_wrap && (bit_q == STOP_BIT_IDX);
  assign TX        = tx_q;

  always_comb begin
    busy_d  = busy_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (trmt && !busy_q) begin
      // The stop bit rides along at shift[8] so the shifter yields it after the data.
      busy_d  = 1'b1;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = {1'b1, tx_data};
      tx_d    = 1'b0;
    end else if (baud_wrap) begin
      baud_d = '0;
      if (bit_q == STOP_BIT_IDX) begin
        busy_d = 1'b0;
        bit_d  = '0;
        tx_d   = 1'b1;
      end else begin
        bit_d   = bit_q + 4'd1;
        tx_d    = shift_q[0];
        shift_d = {1'b1, shift_q[8:1]};
      end
    end else if (busy_q) begin
      baud_d = baud_q + 13'd1;
    end else begin
      tx_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      tx_q    <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/cmd_sender.sv
// Sends a 16-bit command as two UART bytes, high byte first, with a one-clock idle gap
// between the bytes. tx_busy and cmd_snt are registered; TX comes straight from uart_tx's flop.
module cmd_sender
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter int FAST_SIM = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  output logic        tx_busy,
  output logic        cmd_snt
);

  localparam int EFF_DIV = effective_baud(BAUD_DIV, FAST_SIM);

  tx_state_e   state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        tx_busy_q, tx_busy_d;
  logic        cmd_snt_q, cmd_snt_d;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;

  assign tx_busy = tx_busy_q;
  assign cmd_snt = cmd_snt_q;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    tx_busy_d = tx_busy_q;
    cmd_snt_d = cmd_snt_q;
    trmt      = 1'b0;
    tx_data   = hold_q[15:8];
    case (state_q)
      IDLE: begin
        // trmt is combinational here so the start bit appears on the acceptance edge.
        if (snd_cmd) begin
          trmt      = 1'b1;
          tx_data   = cmd[15:8];
          hold_d    = cmd;
          cmd_snt_d = 1'b0;
          tx_busy_d = 1'b1;
          state_d   = SEND_HI;
        end else begin
          tx_busy_d = 1'b0;
        end
      end
      SEND_HI: begin
        if (tx_done) begin
          state_d = GAP;
        end else begin
          state_d = SEND_HI;
        end
      end
      GAP: begin
        trmt    = 1'b1;
        tx_data = hold_q[7:0];
        state_d = SEND_LO;
      end
      SEND_LO: begin
        // A request already pending at completion is accepted next cycle, so cmd_snt
        // is left low to avoid a one-cycle blip between back-to-back commands.
        if (tx_done) begin
          state_d   = IDLE;
          tx_busy_d = 1'b0;
          cmd_snt_d = ~snd_cmd;
        end else begin
          state_d = SEND_LO;
        end
      end
      default: begin
        state_d   = IDLE;
        tx_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      tx_busy_q <= 1'b0;
      cmd_snt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      tx_busy_q <= tx_busy_d;
      cmd_snt_q <= cmd_snt_d;
    end
  end

  uart_tx #(
    .BAUD_DIV(EFF_DIV)
  ) u_uart_tx (
    .clk    (clk),
    .rst    (rst),
    .trmt   (trmt),
    .tx_data(tx_data),
    .TX     (TX),
    .tx_done(tx_done)
  );

endmodule

// File: tb/tb_cmd_sender.sv
// Randomized bench for cmd_sender: expected TX line per clock is built from the frame
// rules (start, 8 data LSB first, stop, 1-clk gap) and compared cycle by cycle.
module tb_cmd_sender;

  localparam int B  = 8;
  localparam int BF = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd, cmd_f;
  logic        snd_cmd, snd_f;
  logic        tx, tx_busy, cmd_snt;
  logic        tx_f, busy_f, snt_f;

  int n_vec = 0;
  int n_err = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  cmd_sender #(.BAUD_DIV(B), .FAST_SIM(0)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .snd_cmd(snd_cmd),
    .TX(tx), .tx_busy(tx_busy), .cmd_snt(cmd_snt)
  );

  cmd_sender #(.BAUD_DIV(4000), .FAST_SIM(1)) dut_fast (
    .clk(clk), .rst(rst), .cmd(cmd_f), .snd_cmd(snd_f),
    .TX(tx_f), .tx_busy(busy_f), .cmd_snt(snt_f)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected TX level for each clock from the acceptance edge to the final stop bit.
  function automatic void build_frame(input logic [15:0] c, input int b);
    logic [7:0] bytes [2];
    bit v;
    bytes[0] = c[15:8];
    bytes[1] = c[7:0];
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      if (i == 1) exp_q.push_back(1'b1);
      for (int n = 0; n < 10; n++) begin
        if (n == 0) v = 1'b0;
        else if (n == 9) v = 1'b1;
        else v = bytes[i][n-1];
        for (int r = 0; r < b; r++) exp_q.push_back(v);
      end
    end
  endfunction

  // noise: 0 none, 1 one 16'hFFFF request at clk 40, 2 random requests/cmd changes.
  task automatic send_frame(input logic [15:0] c, input int noise, input bit hold_next,
                            input int abort_at);
    build_frame(c, B);
    cmd     = c;
    snd_cmd = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 20*B; k++) begin
      @(negedge clk);
      check_eq($sformatf("tx[%0d] cmd %h", k, c), tx, exp_q[k]);
      check_eq($sformatf("busy[%0d]", k), tx_busy, 1'b1);
      check_eq($sformatf("snt[%0d]", k), cmd_snt, 1'b0);
      snd_cmd = 1'b0;
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort tx", tx, 1'b1);
        check_eq("abort busy", tx_busy, 1'b0);
        check_eq("abort snt", cmd_snt, 1'b0);
        rst = 1'b0;
        return;
      end
      if (k == 20*B) begin
        snd_cmd = hold_next;
      end else if (noise == 1 && k == 39) begin
        snd_cmd = 1'b1;
        cmd     = 16'hFFFF;
      end else if (noise == 2) begin
        snd_cmd = 1'($urandom_range(0, 1));
        cmd     = 16'($urandom);
      end
    end
    @(negedge clk);
    check_eq("done tx", tx, 1'b1);
    check_eq("done busy", tx_busy, 1'b0);
    check_eq("done snt", cmd_snt, !hold_next);
    if (!hold_next) begin
      repeat (2) begin
        @(negedge clk);
        check_eq("idle tx", tx, 1'b1);
        check_eq("idle snt", cmd_snt, 1'b1);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    cmd     = 16'h0000;
    snd_cmd = 1'b0;
    cmd_f   = 16'h0000;
    snd_f   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst tx", tx, 1'b1);
    check_eq("rst busy", tx_busy, 1'b0);
    check_eq("rst snt", cmd_snt, 1'b0);
    check_eq("rst fast tx", tx_f, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_frame(16'hA5C3, 0, 1'b0, -1);
    send_frame(16'h0E79, 1, 1'b0, -1);
    for (int i = 0; i < 4; i++) send_frame(16'($urandom), 2, 1'b0, -1);

    // Reset during bit 4 of the low byte, then a clean send.
    send_frame(16'($urandom), 0, 1'b0, 10*B + 1 + 4*B + 2);
    send_frame(16'h1234, 0, 1'b0, -1);

    // Request held high across two commands.
    send_frame(16'h3C5A, 0, 1'b1, -1);
    send_frame(16'($urandom), 0, 1'b0, -1);

    // FAST_SIM instance: every bit lasts 16 clocks despite its large BAUD_DIV.
    build_frame(16'h5A3C, BF);
    cmd_f = 16'h5A3C;
    snd_f = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 20*BF; k++) begin
      @(negedge clk);
      snd_f = 1'b0;
      check_eq($sformatf("fast tx[%0d]", k), tx_f, exp_q[k]);
    end
    @(negedge clk);
    check_eq("fast snt", snt_f, 1'b1);
    check_eq("fast busy", busy_f, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
